// File: rtl/instr_encoder.sv
// Instruction encoder: packs register/funct/immediate fields into a 32-bit word.
// Out-of-range I-type immediates can be split into a LUI plus I-type pair.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  imm_src,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    input  logic        expand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err,
    output logic        last
);

    // state     | meaning
    // EMPTY     | no word held
    // FULL      | one word presented on instr
    // FULL_PEND | first word presented, second word held in pend_q
    typedef enum logic [1:0] {EMPTY, FULL, FULL_PEND} state_t;

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_R = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pend_q, pend_d;
    logic        err_q, err_d;
    logic        last_q, last_d;
    logic        out_valid_q, out_valid_d;

    logic [2:0]         fmt;
    logic signed [31:0] simm;
    logic               legal;
    logic               split;
    logic [19:0]        hi20;
    logic [31:0]        enc_word;
    logic [31:0] lui_word;
    logic [31:0] second_word;
    logic               load;

    always_comb begin
        fmt  = (imm_src > FMT_J) ? FMT_I : imm_src;
        simm = imm;
        legal = 1'b1;
        enc_word = 32'd0;
        case (fmt)
            FMT_S: begin
                legal    = (simm >= -32'sd2048) && (simm <= 32'sd2047);
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            end
            FMT_B: begin
                legal    = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            end
            FMT_R: begin
                legal    = 1'b1;
                enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            FMT_U: begin
                legal    = (simm >= -32'sd524288) && (simm <= 32'sd524287);
                enc_word = {imm[19:0], rd, opcode};
            end
            FMT_J: begin
                legal    = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm[0];
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            end
            default: begin
                legal    = (simm >= -32'sd2048) && (simm <= 32'sd2047);
                enc_word = {imm[11:0], rs1, funct3, rd, opcode};
            end
        endcase

        // (imm + 0x800) >> 12, truncated to 20 bits: upper bits plus rounding carry from bit 11
        hi20        = imm[31:12] + {19'd0, imm[11]};
        split       = (fmt == FMT_I) && expand && !legal;
        lui_word    = {hi20, rd, 7'b0110111};
        second_word = {imm[11:0], rd, funct3, rd, opcode};
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pend_d      = pend_q;
        err_d       = err_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        load        = 1'b0;

        case (state_q)
            EMPTY: begin
                in_ready = 1'b1;
                load     = in_valid;
            end
            FULL: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d     = EMPTY;
                        out_valid_d = 1'b0;
                    end
                end
            end
            FULL_PEND: begin
                if (out_ready) begin
                    state_d = FULL;
                    instr_d = pend_q;
                    err_d   = 1'b0;
                    last_d  = 1'b1;
                end
            end
            default: begin
                state_d     = EMPTY;
                out_valid_d = 1'b0;
            end
        endcase

        if (load) begin
            out_valid_d = 1'b1;
            if (split) begin
                state_d = FULL_PEND;
                instr_d = lui_word;
                pend_d  = second_word;
                err_d   = 1'b0;
                last_d  = 1'b0;
            end else begin
                state_d = FULL;
                instr_d = enc_word;
                err_d   = !legal;
                last_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            instr_q     <= 32'd0;
            pend_q      <= 32'd0;
            err_q       <= 1'b0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign instr     = instr_q;
    assign err       = err_q;
    assign last      = last_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-002 in_valid  input  1  request holds a valid encode command.
REQ-003 in_ready  output  1  block can accept a command this cycle.
REQ-004 imm_src  input  3  format: 000 I, 001 S, 010 B, 011 R, 100 U, 101 J; 110/111 treated as I.
REQ-005 opcode  input  7  opcode field. funct3 input 3. funct7 input 7. These SHALL be copied verbatim where the format has them.
REQ-006 rd, rs1, rs2  input  5 each  register fields.
REQ-007 imm  input  32  signed immediate value to encode.
REQ-008 expand  input  1  allow I-type two-word expansion when imm is out of range.
REQ-009 out_valid  output  1  instr is valid.
REQ-010 out_ready  input  1  consumer accepts instr.
REQ-011 instr  output  32  encoded instruction word.
REQ-012 err  output  1  range or alignment error flag that accompanies the current word.
REQ-013 last  output  1  current word is the final word of its command.

Function
REQ-014 A command SHALL be accepted on in_valid&&in_ready, and its first word SHALL be registered so that out_valid=1 in the next cycle (latency 1).
REQ-015 The block SHALL use three states: EMPTY, FULL, and FULL_PEND (first word is output and a second word is held).
REQ-016 in_ready SHALL be 1 in EMPTY, equal to out_ready in FULL, and 0 in FULL_PEND.
REQ-017 Transitions SHALL be: EMPTY->FULL or FULL_PEND on accept; FULL->EMPTY on out_ready with no accept; FULL->FULL or FULL_PEND on out_ready with a simultaneous accept; FULL_PEND->FULL on out_ready, which loads the second word.
REQ-018 While out_valid=1 and out_ready=0, instr, err, and last SHALL hold stable.
REQ-019 Bit mappings:
- I: instr[31:20]=imm[11:0]
- S: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0]
- B: instr[31]=imm[12], instr[30:25]=imm[10:5], instr[11:8]=imm[4:1], instr[7]=imm[11]
- U: instr[31:12]=imm[19:0]
- J: instr[31]=imm[20], instr[30:21]=imm[10:1], instr[20]=imm[11], instr[19:12]=imm[19:12]
- R: instr[31:25]=funct7; imm is ignored.
- Unused register and funct fields per format SHALL be taken from the inputs.
REQ-020 Legal ranges:
- I and S: -2048..2047
- B: -4096..4094, even
- U: -2^19..2^19-1
- J: -2^20..2^20-2, even
- R: always legal
REQ-021 An illegal command SHALL still emit one word with truncated fields, and with err=1 and last=1.
REQ-022 An I-format command with expand=1 and imm outside -2048..2047 SHALL emit two words, both with err=0:
- Word 1: hi=(imm+32'h800)>>12 (logical), instr={hi[19:0], rd, 7'b0110111}, last=0.
- Word 2: I-format with the input opcode and funct3, rs1=rd, imm[11:0], last=1.
REQ-023 For I-format with expand=1 and imm in range, the block SHALL emit one word only.
REQ-024 Arithmetic SHALL be 32-bit with wrap-around, so imm=32'h7FFFF900 gives hi=32'h80000 truncated to 20 bits.
REQ-025 The second word SHALL be computed at accept time from registered inputs, and changes to the inputs after accept SHALL NOT affect it.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL enter EMPTY, and out_valid, err, last, and instr SHALL go to 0 in the next cycle; in_ready SHALL be 1 in the cycle after rst deasserts.
REQ-027 A reset in FULL or FULL_PEND SHALL discard both the current and the pending word, and no stale word SHALL appear after reset.
REQ-028 in_valid SHALL be ignored in any cycle where rst=1.

Verification
REQ-029 I-format ADDI: opcode=0010011, funct3=000, rd=5, rs1=0, imm=-1, expand=0 -> one cycle later instr=32'hFFF00293, err=0, last=1.
REQ-030 B-format BEQ: opcode=1100011, funct3=000, rs1=1, rs2=2, imm=-4 -> instr=32'hFE208EE3, err=0; imm=3 -> err=1, last=1.
REQ-031 Expansion: imm=32'h12345FFF, rd=10, I-format ADDI, expand=1 -> word 1 32'h12346537 (last=0), then word 2 32'hFFF50513 (last=1); in_ready=0 until word 1 is consumed.
REQ-032 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> instr, err, and last stable; in_ready=0; no command lost; the next command is accepted in the same cycle out_ready rises.
REQ-033 Reset mid-expansion: assert rst while in FULL_PEND -> out_valid=0 the next cycle, and the second word is never emitted.
REQ-034 Back-to-back streaming: out_ready=1 and in_valid=1 for 8 single-word commands -> 8 words on 8 consecutive cycles, in order, with no bubbles.
